// File: rtl/mem_arbiter.sv
// Arbitrates one shared RAM port between instruction fetch and data access, data first unless fetch is starved.
// Latency: grant one cycle after request seen in IDLE; completion reported combinationally on ramstate ACCESS.
// Backpressure: requesters hold request/address while wait=1; RAM BUSY/FREE holds the beat, ERROR re-arbitrates.
module mem_arbiter #(
    parameter int WORD_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    output logic              iwait,
    output logic [WORD_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              dwait,
    output logic [WORD_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);
    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    typedef enum logic [1:0] {IDLE, ISERV, DSERV} state_t;

    state_t           state;
    logic [CNT_W-1:0] starve_cnt;
    logic             armed;
    logic             dreq;
    logic             done;
    logic             err;

    assign dreq = dREN | dWEN;
    assign done = (ramstate == RAM_ACCESS);
    assign err  = (ramstate == RAM_ERROR);

    // armed holds off arbitration for the first edge after reset release
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            starve_cnt <= '0;
            armed      <= 1'b0;
        end else begin
            armed <= 1'b1;
            case (state)
                IDLE: begin
                    if (!iREN)
                        starve_cnt <= '0;
                    if (armed) begin
                        if (dreq && ((starve_cnt < CNT_MAX) || !iREN))
                            state <= DSERV;
                        else if (iREN)
                            state <= ISERV;
                    end
                end
                ISERV: begin
                    if (!iREN || err) begin
                        state <= IDLE;
                    end else if (done) begin
                        state      <= IDLE;
                        starve_cnt <= '0;
                    end
                end
                DSERV: begin
                    if (!dreq || err) begin
                        state <= IDLE;
                    end else if (done) begin
                        state <= IDLE;
                        if (iREN && (starve_cnt != CNT_MAX))
                            starve_cnt <= starve_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // outputs follow state combinationally so completion and abort act in the same cycle
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        case (state)
            ISERV: begin
                if (iREN) begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr;
                    iload   = ramload;
                    iwait   = !done;
                end
            end
            DSERV: begin
                if (dreq) begin
                    ramaddr  = daddr;
                    ramstore = dstore;
                    ramWEN   = dWEN;
                    ramREN   = !dWEN;
                    dload    = dWEN ? '0 : ramload;
                    dwait    = !done;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed-vector bench for mem_arbiter; inputs change at falling edge, outputs checked 1 time unit later.
module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN;
    logic [31:0] iload, dload, ramaddr, ramstore;

    int checks   = 0;
    int failures = 0;

    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

    mem_arbiter #(.WORD_W(32), .STARVE_MAX(4)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // advance one cycle: input changes land after the falling edge, checks 1 unit later
    task automatic nxt();
        @(negedge CLK);
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        nRST = 1'b0; iREN = 1'b1; dREN = 1'b0; dWEN = 1'b1;
        iaddr = 32'h0; daddr = 32'h0; dstore = 32'h0; ramload = 32'h1111_1111; ramstate = ACCESS;
        #3;
        chk("rst_ramREN", ramREN, 0);
        chk("rst_ramWEN", ramWEN, 0);
        chk("rst_ramaddr", ramaddr, 0);
        chk("rst_ramstore", ramstore, 0);
        chk("rst_iwait", iwait, 1);
        chk("rst_dwait", dwait, 1);
        chk("rst_iload", iload, 0);
        chk("rst_dload", dload, 0);
        nxt(); nxt();
        iREN = 0; dWEN = 0; ramstate = FREE; nRST = 1'b1;
        nxt(); nxt();

        // instruction read with two BUSY cycles
        iREN = 1; iaddr = 32'h100; ramstate = FREE; settle();
        chk("i_c0_ramREN", ramREN, 0);
        nxt(); ramstate = BUSY; settle();
        chk("i_c1_ramREN", ramREN, 1);
        chk("i_c1_ramaddr", ramaddr, 32'h100);
        chk("i_c1_iwait", iwait, 1);
        nxt(); settle();
        chk("i_c2_ramREN", ramREN, 1);
        chk("i_c2_iwait", iwait, 1);
        nxt(); ramstate = ACCESS; ramload = 32'h8C22_0004; settle();
        chk("i_c3_ramREN", ramREN, 1);
        chk("i_c3_iwait", iwait, 0);
        chk("i_c3_iload", iload, 32'h8C22_0004);
        chk("i_c3_dwait", dwait, 1);
        nxt(); iREN = 0; ramstate = FREE; settle();
        chk("i_c4_ramREN", ramREN, 0);
        chk("i_c4_iwait", iwait, 1);
        chk("i_c4_iload", iload, 0);

        // simultaneous instruction read and data write: data first
        nxt(); iREN = 1; iaddr = 32'h104; dWEN = 1; daddr = 32'h200; dstore = 32'hDEAD_BEEF; settle();
        chk("w_c0_ramWEN", ramWEN, 0);
        nxt(); ramstate = ACCESS; ramload = 32'h0000_1234; settle();
        chk("w_c1_ramWEN", ramWEN, 1);
        chk("w_c1_ramREN", ramREN, 0);
        chk("w_c1_ramaddr", ramaddr, 32'h200);
        chk("w_c1_ramstore", ramstore, 32'hDEAD_BEEF);
        chk("w_c1_dwait", dwait, 0);
        chk("w_c1_dload", dload, 0);
        chk("w_c1_iwait", iwait, 1);
        nxt(); dWEN = 0; settle();
        chk("w_c2_idle_ramREN", ramREN, 0);
        chk("w_c2_idle_ramWEN", ramWEN, 0);
        chk("w_c2_idle_iwait", iwait, 1);
        nxt(); settle();
        chk("w_c3_ramREN", ramREN, 1);
        chk("w_c3_ramaddr", ramaddr, 32'h104);
        chk("w_c3_iwait", iwait, 0);
        nxt(); iREN = 0; ramstate = FREE; settle();
        chk("w_c4_ramREN", ramREN, 0);

        // starvation limit: four data completions then the fetch
        nxt(); iREN = 1; iaddr = 32'h400; dREN = 1; daddr = 32'h300; ramstate = ACCESS;
        for (int k = 0; k < 4; k++) begin
            ramload = 32'hAAAA_0000 + 32'(k); settle();
            chk("s_idle_ramREN", ramREN, 0);
            nxt(); settle();
            chk("s_d_ramaddr", ramaddr, 32'h300);
            chk("s_d_dwait", dwait, 0);
            chk("s_d_dload", dload, 32'hAAAA_0000 + 32'(k));
            chk("s_d_iwait", iwait, 1);
            nxt();
        end
        settle();
        chk("s_idle4_ramREN", ramREN, 0);
        nxt(); settle();
        chk("s_i_ramaddr", ramaddr, 32'h400);
        chk("s_i_iwait", iwait, 0);
        chk("s_i_dwait", dwait, 1);
        nxt(); settle();
        chk("s_idle5_ramREN", ramREN, 0);
        nxt(); settle();
        chk("s_after_ramaddr", ramaddr, 32'h300);
        chk("s_after_dwait", dwait, 0);
        nxt(); iREN = 0; dREN = 0; ramstate = FREE;

        // ERROR during fetch: back to IDLE, re-granted, later completes
        nxt(); iREN = 1; iaddr = 32'h500; settle();
        chk("e_c0_ramREN", ramREN, 0);
        nxt(); ramstate = ERROR; settle();
        chk("e_c1_ramREN", ramREN, 1);
        chk("e_c1_iwait", iwait, 1);
        nxt(); ramstate = FREE; settle();
        chk("e_c2_ramREN", ramREN, 0);
        chk("e_c2_iwait", iwait, 1);
        nxt(); ramstate = BUSY; settle();
        chk("e_c3_ramREN", ramREN, 1);
        chk("e_c3_ramaddr", ramaddr, 32'h500);
        nxt(); ramstate = ACCESS; ramload = 32'h0000_0055; settle();
        chk("e_c4_iwait", iwait, 0);
        chk("e_c4_iload", iload, 32'h55);
        nxt(); iREN = 0; ramstate = FREE;

        // data read aborted before ACCESS
        nxt(); dREN = 1; daddr = 32'h600; ramstate = BUSY; settle();
        chk("a_c0_ramREN", ramREN, 0);
        nxt(); settle();
        chk("a_c1_ramREN", ramREN, 1);
        chk("a_c1_ramaddr", ramaddr, 32'h600);
        chk("a_c1_dwait", dwait, 1);
        nxt(); dREN = 0; settle();
        chk("a_c2_ramREN", ramREN, 0);
        chk("a_c2_dwait", dwait, 1);
        nxt(); ramstate = ACCESS; settle();
        chk("a_c3_ramREN", ramREN, 0);
        chk("a_c3_dwait", dwait, 1);
        nxt(); ramstate = BUSY;

        // reset asserted in the middle of a data write
        nxt(); dWEN = 1; daddr = 32'h700; dstore = 32'h0000_0077; settle();
        chk("r_c0_ramWEN", ramWEN, 0);
        nxt(); settle();
        chk("r_c1_ramWEN", ramWEN, 1);
        chk("r_c1_ramstore", ramstore, 32'h77);
        nRST = 0; settle();
        chk("r_async_ramWEN", ramWEN, 0);
        chk("r_async_ramaddr", ramaddr, 0);
        chk("r_async_ramstore", ramstore, 0);
        ramstate = ACCESS; settle();
        chk("r_async_dwait", dwait, 1);
        chk("r_async_dload", dload, 0);
        nxt(); nRST = 1; ramstate = FREE; settle();
        chk("r_rel0_ramWEN", ramWEN, 0);
        nxt(); settle();
        chk("r_rel1_ramWEN", ramWEN, 0);
        nxt(); settle();
        chk("r_rel2_ramWEN", ramWEN, 1);
        chk("r_rel2_ramaddr", ramaddr, 32'h700);
        ramstate = ACCESS; settle();
        chk("r_rel2_dwait", dwait, 0);
        nxt(); dWEN = 0; ramstate = FREE; settle();
        chk("r_end_dwait", dwait, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
